// File: rtl/branch_target_table_if.sv
// Load-stream and lookup signals of the branch target table, bundled for module ports.
// master drives loads and lookups; slave is the table itself.
interface branch_target_table_if #(
    parameter int ADDR_W = 5,
    parameter int TGT_W  = 10,
    parameter int DEPTH  = 14
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              LoadStart;
    logic              LoadValid;
    logic [TGT_W-1:0]  LoadData;
    logic              LoadEnd;
    logic              LoadReady;
    logic              LoadDone;
    logic [CNT_W-1:0]  Count;
    logic [ADDR_W-1:0] Addr;
    logic [TGT_W-1:0]  Target;
    logic              Miss;

    modport master (
        output LoadStart, LoadValid, LoadData, LoadEnd, Addr,
        input  LoadReady, LoadDone, Count, Target, Miss
    );

    modport slave (
        input  LoadStart, LoadValid, LoadData, LoadEnd, Addr,
        output LoadReady, LoadDone, Count, Target, Miss
    );
endinterface

// File: rtl/branch_target_table.sv
// Runtime-loadable pointer -> PC target table, 1-cycle registered lookup, streaming load port.
// Optional BTT_MISS_FLAG_EN adds per-entry valid bits and a real Miss flag; otherwise Miss is 0.
module branch_target_table #(
    parameter int ADDR_W = 5,
    parameter int TGT_W  = 10,
    parameter int BASE   = 16,
    parameter int DEPTH  = 14
) (
    input  logic                 Clk,
    input  logic                 Reset,
    branch_target_table_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [ADDR_W:0] WIN_LO = (ADDR_W+1)'(BASE);
    localparam logic [ADDR_W:0] WIN_HI = (ADDR_W+1)'(BASE + DEPTH);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TGT_W-1:0]  mem_q [DEPTH];
    logic [TGT_W-1:0]  mem_d [DEPTH];
    logic              done_q, done_d;
    logic [TGT_W-1:0]  target_q, target_d;
    logic [PTR_W-1:0]  idx;
    logic              in_win;
    logic              hit;
`ifdef BTT_MISS_FLAG_EN
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              miss_q, miss_d;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        mem_d   = mem_q;
        done_d  = 1'b0;
`ifdef BTT_MISS_FLAG_EN
        valid_d = valid_q;
`endif
        // A start pulse opens a fresh session from either state; no done pulse on restart.
        if (bus.LoadStart) begin
            state_d = LOAD;
            ptr_d   = '0;
            count_d = '0;
`ifdef BTT_MISS_FLAG_EN
            valid_d = '0;
`endif
        end else if (state_q == LOAD) begin
            if (bus.LoadValid) begin
                mem_d[ptr_q] = bus.LoadData;
`ifdef BTT_MISS_FLAG_EN
                valid_d[ptr_q] = 1'b1;
`endif
                ptr_d = ptr_q + PTR_W'(1);
                if (count_q != CNT_W'(DEPTH))
                    count_d = count_q + CNT_W'(1);
            end
            if ((bus.LoadValid && ptr_q == PTR_W'(DEPTH - 1)) || bus.LoadEnd) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    // Lookup only hits in IDLE so a half-written table is never exposed.
    always_comb begin
        idx    = PTR_W'(bus.Addr - ADDR_W'(BASE));
        in_win = ({1'b0, bus.Addr} >= WIN_LO) && ({1'b0, bus.Addr} < WIN_HI);
`ifdef BTT_MISS_FLAG_EN
        hit    = in_win && (state_q == IDLE) && valid_q[idx];
        miss_d = ~hit;
`else
        hit    = in_win && (state_q == IDLE);
`endif
        target_d = hit ? mem_q[idx] : '0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            target_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
`ifdef BTT_MISS_FLAG_EN
            valid_q  <= '0;
            miss_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            count_q  <= count_d;
            done_q   <= done_d;
            target_q <= target_d;
            mem_q    <= mem_d;
`ifdef BTT_MISS_FLAG_EN
            valid_q  <= valid_d;
            miss_q   <= miss_d;
`endif
        end
    end

    assign bus.LoadReady = (state_q == LOAD);
    assign bus.LoadDone  = done_q;
    assign bus.Count     = count_q;
    assign bus.Target    = target_q;
`ifdef BTT_MISS_FLAG_EN
    assign bus.Miss      = miss_q;
`else
    assign bus.Miss      = 1'b0;
`endif
endmodule

// File: tb/tb_branch_target_table.sv
// Directed bench for branch_target_table; expectations follow BTT_MISS_FLAG_EN when defined.
module tb_branch_target_table;
    localparam int ADDR_W = 5;
    localparam int TGT_W  = 10;
    localparam int BASE   = 16;
    localparam int DEPTH  = 14;
`ifdef BTT_MISS_FLAG_EN
    localparam bit MISS_ON = 1'b1;
`else
    localparam bit MISS_ON = 1'b0;
`endif

    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_bad;
    int   done_cnt;

    branch_target_table_if #(.ADDR_W(ADDR_W), .TGT_W(TGT_W), .DEPTH(DEPTH)) bus ();

    branch_target_table #(.ADDR_W(ADDR_W), .TGT_W(TGT_W), .BASE(BASE), .DEPTH(DEPTH)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk) if (bus.LoadDone === 1'b1) done_cnt++;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic lookup(input logic [ADDR_W-1:0] a, output logic [TGT_W-1:0] t, output logic m);
        bus.Addr = a;
        tick();
        t = bus.Target;
        m = bus.Miss;
    endtask

    task automatic test_reset();
        logic [TGT_W-1:0] t;
        logic m;
        Reset = 1'b1;
        bus.LoadStart = 0; bus.LoadValid = 0; bus.LoadData = '0; bus.LoadEnd = 0; bus.Addr = '0;
        #12;
        n_cmp++; if (bus.LoadReady !== 1'b0) begin n_bad++; $display("FAIL rst_ready got %b want 0", bus.LoadReady); end
        n_cmp++; if (bus.LoadDone !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.LoadDone); end
        n_cmp++; if (bus.Count !== 4'd0) begin n_bad++; $display("FAIL rst_count got %0d want 0", bus.Count); end
        n_cmp++; if (bus.Miss !== MISS_ON) begin n_bad++; $display("FAIL rst_miss got %b want %b", bus.Miss, MISS_ON); end
        Reset = 1'b0;
        tick();
        lookup(5'b10000, t, m);
        n_cmp++; if (t !== 10'd0) begin n_bad++; $display("FAIL rst_lookup_tgt got %0d want 0", t); end
        n_cmp++; if (m !== MISS_ON) begin n_bad++; $display("FAIL rst_lookup_miss got %b want %b", m, MISS_ON); end
    endtask

    task automatic test_full_load();
        logic [TGT_W-1:0] beats [DEPTH] = '{4, 64, 166, 73, 131, 135, 218, 177, 270, 228, 318, 280, 312, 314};
        logic [TGT_W-1:0] t;
        logic m;
        done_cnt = 0;
        bus.LoadStart = 1'b1;
        tick();
        bus.LoadStart = 1'b0;
        n_cmp++; if (bus.LoadReady !== 1'b1) begin n_bad++; $display("FAIL full_ready_rise got %b want 1", bus.LoadReady); end
        for (int i = 0; i < DEPTH; i++) begin
            bus.LoadValid = 1'b1;
            bus.LoadData  = beats[i];
            tick();
        end
        bus.LoadValid = 1'b0;
        n_cmp++; if (bus.LoadReady !== 1'b0 || bus.LoadDone !== 1'b1) begin
            n_bad++; $display("FAIL full_close got ready=%b done=%b want ready=0 done=1", bus.LoadReady, bus.LoadDone); end
        lookup(5'b10011, t, m);
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (bus.Count !== 4'd14) begin n_bad++; $display("FAIL full_count got %0d want 14", bus.Count); end
        n_cmp++; if (t !== 10'd73 || m !== 1'b0) begin n_bad++; $display("FAIL full_lookup3 got %0d/%b want 73/0", t, m); end
        lookup(5'b10000, t, m);
        n_cmp++; if (t !== 10'd4) begin n_bad++; $display("FAIL full_lookup_first got %0d want 4", t); end
        lookup(5'b11101, t, m);
        n_cmp++; if (t !== 10'd314) begin n_bad++; $display("FAIL full_lookup_last got %0d want 314", t); end
    endtask

    task automatic test_out_of_window();
        logic [TGT_W-1:0] t;
        logic m;
        lookup(5'b01111, t, m);
        n_cmp++; if (t !== 10'd0 || m !== MISS_ON) begin n_bad++; $display("FAIL oow_low got %0d/%b want 0/%b", t, m, MISS_ON); end
        lookup(5'b11110, t, m);
        n_cmp++; if (t !== 10'd0 || m !== MISS_ON) begin n_bad++; $display("FAIL oow_high got %0d/%b want 0/%b", t, m, MISS_ON); end
    endtask

    task automatic test_short_session();
        logic [TGT_W-1:0] beats [3] = '{10, 20, 30};
        logic [TGT_W-1:0] t;
        logic m;
        bus.Addr = 5'b10000;
        bus.LoadStart = 1'b1;
        tick();
        bus.LoadStart = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.LoadValid = 1'b1;
            bus.LoadData  = beats[i];
            bus.LoadEnd   = (i == 2);
            tick();
            if (i == 0) begin
                n_cmp++; if (bus.Target !== 10'd0 || bus.Miss !== MISS_ON) begin
                    n_bad++; $display("FAIL short_lookup_in_load got %0d/%b want 0/%b", bus.Target, bus.Miss, MISS_ON); end
            end
        end
        bus.LoadValid = 1'b0;
        bus.LoadEnd   = 1'b0;
        n_cmp++; if (bus.LoadDone !== 1'b1 || bus.Count !== 4'd3) begin
            n_bad++; $display("FAIL short_close got done=%b count=%0d want done=1 count=3", bus.LoadDone, bus.Count); end
        lookup(5'b10010, t, m);
        n_cmp++; if (t !== 10'd30 || m !== 1'b0) begin n_bad++; $display("FAIL short_lookup2 got %0d/%b want 30/0", t, m); end
        lookup(5'b10011, t, m);
        n_cmp++; if (t !== (MISS_ON ? 10'd0 : 10'd73) || m !== MISS_ON) begin
            n_bad++; $display("FAIL short_lookup3 got %0d/%b want %0d/%b", t, m, MISS_ON ? 0 : 73, MISS_ON); end
        // LoadEnd in IDLE must not start or close anything.
        bus.LoadEnd = 1'b1;
        tick();
        bus.LoadEnd = 1'b0;
        tick();
        n_cmp++; if (bus.LoadReady !== 1'b0 || bus.LoadDone !== 1'b0 || bus.Count !== 4'd3) begin
            n_bad++; $display("FAIL idle_end got ready=%b done=%b count=%0d want 0/0/3", bus.LoadReady, bus.LoadDone, bus.Count); end
    endtask

    task automatic test_restart();
        logic [TGT_W-1:0] t;
        logic m;
        done_cnt = 0;
        bus.LoadStart = 1'b1;
        tick();
        bus.LoadStart = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.LoadValid = 1'b1;
            bus.LoadData  = TGT_W'(100 + i);
            tick();
        end
        bus.LoadValid = 1'b0;
        bus.LoadStart = 1'b1;
        tick();
        bus.LoadStart = 1'b0;
        n_cmp++; if (bus.LoadReady !== 1'b1 || bus.LoadDone !== 1'b0 || bus.Count !== 4'd0) begin
            n_bad++; $display("FAIL restart_state got ready=%b done=%b count=%0d want 1/0/0", bus.LoadReady, bus.LoadDone, bus.Count); end
        bus.LoadValid = 1'b1; bus.LoadData = 10'd7; tick();
        bus.LoadData = 10'd9; tick();
        bus.LoadValid = 1'b0; bus.LoadEnd = 1'b1; tick();
        bus.LoadEnd = 1'b0;
        lookup(5'b10001, t, m);
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL restart_done_count got %0d want 1", done_cnt); end
        n_cmp++; if (bus.Count !== 4'd2) begin n_bad++; $display("FAIL restart_count got %0d want 2", bus.Count); end
        n_cmp++; if (t !== 10'd9) begin n_bad++; $display("FAIL restart_lookup1 got %0d want 9", t); end
    endtask

    task automatic test_reset_mid();
        logic [TGT_W-1:0] t;
        logic m;
        done_cnt = 0;
        bus.LoadStart = 1'b1;
        tick();
        bus.LoadStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.LoadValid = 1'b1;
            bus.LoadData  = TGT_W'(200 + i);
            tick();
        end
        bus.LoadValid = 1'b0;
        Reset = 1'b1;
        #1;
        n_cmp++; if (bus.LoadReady !== 1'b0 || bus.Count !== 4'd0) begin
            n_bad++; $display("FAIL rstmid_async got ready=%b count=%0d want 0/0", bus.LoadReady, bus.Count); end
        tick();
        Reset = 1'b0;
        // A stray beat in IDLE must write nothing.
        bus.LoadValid = 1'b1; bus.LoadData = 10'd55; tick();
        bus.LoadValid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            lookup(ADDR_W'(BASE + i), t, m);
            n_cmp++; if (t !== 10'd0) begin n_bad++; $display("FAIL rstmid_lookup%0d got %0d want 0", i, t); end
        end
        n_cmp++; if (done_cnt !== 0 || bus.Count !== 4'd0) begin
            n_bad++; $display("FAIL rstmid_done got done_cnt=%0d count=%0d want 0/0", done_cnt, bus.Count); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        done_cnt = 0;
        test_reset();
        test_full_load();
        test_out_of_window();
        test_short_session();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_target_table.md
# branch_target_table

Runtime-loadable branch target table: a parametrised successor to the fixed-case PC target lookup. It maps a narrow branch-pointer field from the instruction to a full-width PC target. Entries are written through a streaming load port before the program runs, instead of being hard-coded per program. It sits beside the program counter: the fetch/branch logic drives `Addr` and consumes `Target` one cycle later.

## Interface
- `ADDR_W`, 5: width of the pointer field from the instruction.
- `TGT_W`, 10: width of a PC target.
- `BASE`, 16: first pointer value mapped to entry 0.
- `DEPTH`, 14: number of entries; requires `BASE+DEPTH <= 2**ADDR_W`.

- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `LoadStart`  in  1  single-cycle pulse; opens a load session.
- `LoadValid`  in  1  load beat valid.
- `LoadData`  in  TGT_W  target value for the current beat.
- `LoadEnd`  in  1  ends a session early; sampled only in LOAD.
- `LoadReady`  out  1  block accepts beats; high exactly in LOAD.
- `LoadDone`  out  1  one-cycle pulse when a session closes.
- `Count`  out  $clog2(DEPTH+1)  number of entries written in the last or current session.
- `Addr`  in  ADDR_W  lookup pointer.
- `Target`  out  TGT_W  registered lookup result.
- `Miss`  out  1  registered; lookup produced no valid target (see Configuration).

## Operation
- Storage: `DEPTH` x `TGT_W` registers plus one valid bit per entry.
- Window: `Addr` in [BASE, BASE+DEPTH) selects entry `Addr-BASE`. Any other pointer is out of window.
- FSM with two states, IDLE and LOAD.
  - IDLE -> LOAD on `LoadStart`. The write pointer clears to 0, `Count` clears to 0, and all valid bits clear.
  - In LOAD, an accepted beat (`LoadValid & LoadReady`) writes `LoadData` to entry[ptr], sets valid[ptr], and increments ptr and `Count`.
  - LOAD -> IDLE when a beat is accepted with ptr == DEPTH-1 (table full), or when `LoadEnd` is high. `LoadDone` pulses the following cycle.
  - `LoadEnd` together with a beat: the beat is written first, then the FSM exits. `Count` includes that beat.
  - `LoadStart` while in LOAD: the session restarts. Pointer, `Count` and valid bits clear, the FSM stays in LOAD, and no `LoadDone` pulse.
  - `LoadEnd` in IDLE is ignored. `LoadValid` in IDLE is ignored and nothing is written.
- Lookup is evaluated every cycle and registered.
  - In IDLE, with `Addr` in window and the entry valid: `Target` = entry, `Miss` = 0.
  - Otherwise (out of window, invalid entry, or state LOAD): `Target` = 0, `Miss` = 1. The value 0 matches the legacy default.
- `Count` saturates at DEPTH and holds its value after the session closes.

## Timing
- Reset values: state IDLE, ptr 0, `Count` 0, all valid bits 0, entries 0, `Target` 0, `Miss` 1, `LoadReady` 0, `LoadDone` 0.
- Reset asserted mid-session aborts the session immediately and clears everything. No `LoadDone`.
- Lookup latency is 1 cycle: `Addr` sampled at edge N is reflected on `Target`/`Miss` after edge N.
- `LoadReady` rises the cycle after `LoadStart`. It falls the cycle after the closing beat or `LoadEnd`, which is the same cycle `LoadDone` is high.
- The first lookup that sees new data is the one sampled on the edge after LOAD exits.
- Throughput is 1 beat per cycle, with no back-pressure inside LOAD.

## Configuration
- `BTT_MISS_FLAG_EN` defined:
  - valid bits are implemented.
  - `Miss` behaves as in Operation.
  - a lookup of an unwritten entry returns 0.
- `BTT_MISS_FLAG_EN` undefined:
  - no valid bits exist.
  - `Miss` is tied to 0.
  - an in-window lookup in IDLE returns the stored entry, which may be 0 from reset or stale from an earlier session.
  - out-of-window and in-LOAD lookups still return 0.

## Test plan
- Reset, then `Addr`=5'b10000 -> `Target`=0. `Miss`=1 with the macro, 0 without it.
- `LoadStart`, then 14 back-to-back beats 4,64,166,73,131,135,218,177,270,228,318,280,312,314 -> auto-close after beat 14 and `LoadDone` pulses once. `Count`=14, and `Addr`=5'b10011 gives `Target`=73 one cycle later.
- Session of 3 beats (10,20,30) with `LoadEnd` high on beat 3 -> `Count`=3. `Addr`=5'b10010 gives 30; `Addr`=5'b10011 gives 0 with `Miss`=1.
- `Addr`=5'b01111 and `Addr`=5'b11110 after a full load -> `Target`=0 and `Miss`=1.
- `LoadStart` after 5 beats, then 2 beats (7,9) and `LoadEnd` -> exactly one `LoadDone`, `Count`=2, and `Addr`=5'b10001 gives 9.
- `Reset` pulsed mid-session after 4 beats -> `LoadReady`=0 immediately, `Count`=0, all lookups 0, and no `LoadDone`.
